fdt_label_seq_dec: RTL and testbench
====================================

# fdt_label_seq_dec

Label-sequence decoder for the FDT path. It consumes the per-frame binary decision stream (`dec_result` / `dec_result_vld`) produced by the NN unit and keeps a sliding history of labels. It applies up/down hysteresis thresholds and drives the software-visible FDT status levels `ro_fdt_result_up` and `ro_fdt_result_down`. It sits directly downstream of the NN unit, in the same clock domain, and owns all `rg_label_*` configuration.

## Interface
Parameters:
- `HIST_W`, default 16: history depth; also the maximum window length.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  asynchronous, active-low reset
- `soft_clr`  in  1  synchronous clear of history, counters and state
- `dec_result`  in  1  NN label, 1 = target present
- `dec_result_vld`  in  1  single-cycle strobe qualifying `dec_result`
- `rg_label_seq_init_en`  in  1  when 1, `soft_clr` enters WARMUP
- `rg_label_dec_mode`  in  1  0 = window-count mode, 1 = consecutive-run mode
- `rg_label_up_memcnt_th`  in  5  up threshold; 0 disables DOWN→UP
- `rg_label_dn_memcnt_th`  in  5  down threshold; 0 disables UP→DOWN
- `rg_label_memseq_len`  in  4  window length L = value + 1 (1..16)
- `ro_fdt_result_up`  out  1  level, 1 while state is UP
- `ro_fdt_result_down`  out  1  level, 1 while state is DOWN

## Operation
- History `hist[15:0]` is a shift register. On an accepted sample: `hist <= {hist[14:0], dec_result}`.
- Window popcount: `ones` = popcount(`hist_next` & mask(L)), where the mask covers the L newest bits. `zeros` = L − `ones`. Both are 5-bit.
- Run counters (mode 1): `run1` and `run0` are 5-bit and saturate at 31.
  - A 1 sample increments `run1` and clears `run0`.
  - A 0 sample does the opposite.
- Warmup counter `wcnt` is 5-bit. It increments per sample while in WARMUP.
- States: WARMUP, DOWN, UP.
  - Mode 0: UP condition is `ones >= up_th` (with `up_th != 0`). DOWN condition is `zeros >= dn_th` (with `dn_th != 0`).
  - Mode 1: the same comparisons use `run1` and `run0` instead of `ones` and `zeros`.
- Transitions, evaluated only on an accepted sample using next-value counts:
  - DOWN→UP on the UP condition.
  - UP→DOWN on the DOWN condition.
  - WARMUP exits when `wcnt + 1 == L`. It goes to UP if the UP condition holds, otherwise to DOWN.
- In WARMUP, both outputs are 0.
- Reset state:
  - state DOWN
  - `hist`, `run1`, `run0` and `wcnt` all 0
  - `ro_fdt_result_up = 0`, `ro_fdt_result_down = 1`
- `soft_clr` does the following:
  - clears `hist`, the run counters and `wcnt`
  - sets the state to WARMUP if `rg_label_seq_init_en` is 1, else DOWN
  - has priority over a coincident `dec_result_vld`; that sample is dropped
- Changing `rg_label_memseq_len` mid-run takes effect on the next sample's popcount, because the mask is combinational. No history is lost.
- A threshold larger than L in mode 0 never fires.

## Timing
- Outputs are registered. They reflect a sample on the cycle after `dec_result_vld` (latency 1).
- Back-to-back `dec_result_vld` is supported: one sample per cycle, no stall, no backpressure.
- `soft_clr` affects outputs on the following cycle.
- Reset is asynchronous assert, synchronous deassert.

## Configuration
- Macro: `FDT_LABEL_EVT_EN`.
- Defined: adds the following outputs, all cleared by reset and by `soft_clr`:
  - `evt_up` (1-bit pulse on a DOWN→UP or WARMUP→UP transition)
  - `evt_down` (1-bit pulse on an UP→DOWN transition)
  - `ro_fdt_up_cnt` (8-bit count of `evt_up`, saturating at 255)
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `fdt_pkg`:
  - `label_state_t` enum {WARMUP, DOWN, UP}
  - `HIST_W`
  - `LABEL_CNT_W = 5`
- Sub-module `fdt_label_win`: contains `hist`, the mask generation and the popcount. It outputs `ones` and `zeros` for the next value.
- The top level holds the run counters, `wcnt`, the FSM and the outputs.

## Test plan
- Reset, then mode 0, L=8, up_th=5, dn_th=5. Stimulus: samples 1,1,1,1,1.
  - `ro_fdt_result_up` rises the cycle after the 5th sample.
  - Then send 0×4: `up` stays 1.
  - The 5th 0 gives `zeros = 5` and flips the state to DOWN.
- Mode 1, up_th=3, dn_th=2. Stimulus: 1,1,0,1,1,1.
  - UP only after the final sample.
  - Then 0,1,0,0: DOWN after the last 0.
- `seq_init_en=1`, L=4, `soft_clr`.
  - Both outputs are 0 for 4 samples.
  - With samples 1,1,1,1 and up_th=3, the output goes straight to UP after the 4th sample.
- `soft_clr` coincident with `dec_result_vld=1`: the sample is dropped.
  - With `seq_init_en=0`, the output is DOWN next cycle and the history is empty.
  - Three subsequent 1s with up_th=4 do not raise `up`.
- up_th=0, continuous 1s for 40 samples: `up` never asserts, and `run1` saturates at 31.
- With `FDT_LABEL_EVT_EN` defined: 300 UP/DOWN toggles give `ro_fdt_up_cnt = 255`. Each `evt_up` and `evt_down` is exactly 1 cycle wide.

Source files
------------

// File: rtl/fdt_pkg.sv
// Shared types and constants for the FDT label-sequence decoder.
package fdt_pkg;

  localparam int HIST_W      = 16;
  localparam int LABEL_CNT_W = 5;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    DOWN   = 2'd1,
    UP     = 2'd2
  } label_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LABEL_CNT_W-1:0] sat_inc(input logic [LABEL_CNT_W-1:0] v);
    return (&v) ? v : v + LABEL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fdt_label_win.sv
// Label history shift register with a variable-length window popcount.
// ones/zeros describe the history as it will be after the current sample.
module fdt_label_win
  import fdt_pkg::*;
#(
  parameter int HIST_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   soft_clr,
  input  logic                   sample_vld,
  input  logic                   sample,
  input  logic [3:0]             memseq_len,
  output logic [LABEL_CNT_W-1:0] ones,
  output logic [LABEL_CNT_W-1:0] zeros
);

  logic [HIST_W-1:0]      hist_reg;
  logic [HIST_W-1:0]      hist_next;
  logic [HIST_W-1:0]      win_mask;
  logic [HIST_W-1:0]      hist_masked;
  logic [LABEL_CNT_W-1:0] win_len;

  // The window covers the memseq_len+1 newest bits; kept combinational so a
  // length change applies to the very next sample without touching history.
  genvar gi;
  generate
    for (gi = 0; gi < HIST_W; gi++) begin : g_mask
      assign win_mask[gi] = (32'(gi) <= 32'(memseq_len));
    end
  endgenerate

  always_comb begin
    hist_next = hist_reg;
    if (soft_clr)
      hist_next = '0;
    else if (sample_vld)
      hist_next = {hist_reg[HIST_W-2:0], sample};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      hist_reg <= '0;
    else
      hist_reg <= hist_next;
  end

  assign hist_masked = hist_next & win_mask;
  assign win_len     = LABEL_CNT_W'(memseq_len) + LABEL_CNT_W'(1);

  always_comb begin
    ones = '0;
    for (int i = 0; i < HIST_W; i++)
      ones = ones + LABEL_CNT_W'(hist_masked[i]);
  end

  assign zeros = win_len - ones;

endmodule

// File: rtl/fdt_label_seq_dec.sv
// FDT label-sequence decoder: hysteresis FSM over window counts or run lengths.
// Optional event outputs (evt_up, evt_down, ro_fdt_up_cnt) under FDT_LABEL_EVT_EN.
module fdt_label_seq_dec
  import fdt_pkg::*;
#(
  parameter int HIST_W = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       soft_clr,
  input  logic       dec_result,
  input  logic       dec_result_vld,
  input  logic       rg_label_seq_init_en,
  input  logic       rg_label_dec_mode,
  input  logic [4:0] rg_label_up_memcnt_th,
  input  logic [4:0] rg_label_dn_memcnt_th,
  input  logic [3:0] rg_label_memseq_len,
  output logic       ro_fdt_result_up,
  output logic       ro_fdt_result_down
`ifdef FDT_LABEL_EVT_EN
  ,
  output logic       evt_up,
  output logic       evt_down,
  output logic [7:0] ro_fdt_up_cnt
`endif
);

  logic                   accept;
  logic [LABEL_CNT_W-1:0] ones;
  logic [LABEL_CNT_W-1:0] zeros;
  logic [LABEL_CNT_W-1:0] run1_reg, run1_next;
  logic [LABEL_CNT_W-1:0] run0_reg, run0_next;
  logic [LABEL_CNT_W-1:0] wcnt_reg, wcnt_next;
  logic [LABEL_CNT_W-1:0] win_len;
  logic [LABEL_CNT_W-1:0] cnt_up;
  logic [LABEL_CNT_W-1:0] cnt_dn;
  logic                   up_cond;
  logic                   dn_cond;
  label_state_t           state_reg, state_next;
  logic                   up_reg;
  logic                   down_reg;

  assign accept = dec_result_vld & ~soft_clr;

  fdt_label_win #(
    .HIST_W(HIST_W)
  ) u_win (
    .clk        (clk),
    .rstn       (rstn),
    .soft_clr   (soft_clr),
    .sample_vld (dec_result_vld),
    .sample     (dec_result),
    .memseq_len (rg_label_memseq_len),
    .ones       (ones),
    .zeros      (zeros)
  );

  always_comb begin
    run1_next = run1_reg;
    run0_next = run0_reg;
    if (soft_clr) begin
      run1_next = '0;
      run0_next = '0;
    end else if (accept) begin
      if (dec_result) begin
        run1_next = sat_inc(run1_reg);
        run0_next = '0;
      end else begin
        run0_next = sat_inc(run0_reg);
        run1_next = '0;
      end
    end
  end

  // Both modes share the threshold compare; only the counted quantity differs.
  assign cnt_up  = rg_label_dec_mode ? run1_next : ones;
  assign cnt_dn  = rg_label_dec_mode ? run0_next : zeros;
  assign up_cond = (rg_label_up_memcnt_th != '0) && (cnt_up >= rg_label_up_memcnt_th);
  assign dn_cond = (rg_label_dn_memcnt_th != '0) && (cnt_dn >= rg_label_dn_memcnt_th);
  assign win_len = LABEL_CNT_W'(rg_label_memseq_len) + LABEL_CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    if (soft_clr) begin
      state_next = rg_label_seq_init_en ? WARMUP : DOWN;
      wcnt_next  = '0;
    end else if (accept) begin
      case (state_reg)
        WARMUP: begin
          wcnt_next = wcnt_reg + LABEL_CNT_W'(1);
          if (wcnt_next == win_len)
            state_next = up_cond ? UP : DOWN;
        end
        DOWN:    if (up_cond) state_next = UP;
        UP:      if (dn_cond) state_next = DOWN;
        default: state_next = DOWN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= DOWN;
      run1_reg  <= '0;
      run0_reg  <= '0;
      wcnt_reg  <= '0;
      up_reg    <= 1'b0;
      down_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      run1_reg  <= run1_next;
      run0_reg  <= run0_next;
      wcnt_reg  <= wcnt_next;
      up_reg    <= (state_next == UP);
      down_reg  <= (state_next == DOWN);
    end
  end

  assign ro_fdt_result_up   = up_reg;
  assign ro_fdt_result_down = down_reg;

`ifdef FDT_LABEL_EVT_EN
  logic       evt_up_reg;
  logic       evt_down_reg;
  logic [7:0] up_cnt_reg;
  logic       evt_up_next;
  logic       evt_down_next;

  assign evt_up_next   = accept && (state_next == UP) && (state_reg != UP);
  assign evt_down_next = accept && (state_reg == UP) && (state_next == DOWN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_up_reg   <= 1'b0;
      evt_down_reg <= 1'b0;
      up_cnt_reg   <= '0;
    end else if (soft_clr) begin
      evt_up_reg   <= 1'b0;
      evt_down_reg <= 1'b0;
      up_cnt_reg   <= '0;
    end else begin
      evt_up_reg   <= evt_up_next;
      evt_down_reg <= evt_down_next;
      if (evt_up_next && (up_cnt_reg != 8'hff))
        up_cnt_reg <= up_cnt_reg + 8'd1;
    end
  end

  assign evt_up        = evt_up_reg;
  assign evt_down      = evt_down_reg;
  assign ro_fdt_up_cnt = up_cnt_reg;
`endif

endmodule

// File: tb/tb_fdt_label_seq_dec.sv
// Scoreboard bench for fdt_label_seq_dec: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared one cycle later.
module tb_fdt_label_seq_dec;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       soft_clr = 1'b0;
  logic       dec_result = 1'b0;
  logic       dec_result_vld = 1'b0;
  logic       init_en = 1'b0;
  logic       mode = 1'b0;
  logic [4:0] up_th = 5'd0;
  logic [4:0] dn_th = 5'd0;
  logic [3:0] len = 4'd0;
  logic       up_o, down_o;
  logic       eu_o, ed_o;
  logic [7:0] cnt_o;

  fdt_label_seq_dec dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .soft_clr              (soft_clr),
    .dec_result            (dec_result),
    .dec_result_vld        (dec_result_vld),
    .rg_label_seq_init_en  (init_en),
    .rg_label_dec_mode     (mode),
    .rg_label_up_memcnt_th (up_th),
    .rg_label_dn_memcnt_th (dn_th),
    .rg_label_memseq_len   (len),
    .ro_fdt_result_up      (up_o),
    .ro_fdt_result_down    (down_o)
`ifdef FDT_LABEL_EVT_EN
    ,
    .evt_up                (eu_o),
    .evt_down              (ed_o),
    .ro_fdt_up_cnt         (cnt_o)
`endif
  );

`ifndef FDT_LABEL_EVT_EN
  assign eu_o  = 1'b0;
  assign ed_o  = 1'b0;
  assign cnt_o = 8'd0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic       up;
    logic       down;
    logic       eu;
    logic       ed;
    logic [7:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  string phase = "reset";

  // model state: 0 WARMUP, 1 DOWN, 2 UP
  logic [15:0] m_hist;
  int          m_run1, m_run0, m_wcnt, m_state, m_cnt;
  logic        m_eu, m_ed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    m_hist = '0; m_run1 = 0; m_run0 = 0; m_wcnt = 0; m_state = 1;
    m_cnt = 0; m_eu = 1'b0; m_ed = 1'b0;
  endfunction

  function automatic void mdl_clr();
    m_hist = '0; m_run1 = 0; m_run0 = 0; m_wcnt = 0;
    m_state = init_en ? 0 : 1;
    m_cnt = 0; m_eu = 1'b0; m_ed = 1'b0;
  endfunction

  function automatic void mdl_sample(input bit b);
    int L, ones, zeros, cu, cd, old;
    bit upc, dnc;
    L = int'(len) + 1;
    m_hist = {m_hist[14:0], b};
    ones = $countones(m_hist & 16'((32'd1 << L) - 1));
    zeros = L - ones;
    if (b) begin m_run1 = (m_run1 < 31) ? m_run1 + 1 : 31; m_run0 = 0; end
    else   begin m_run0 = (m_run0 < 31) ? m_run0 + 1 : 31; m_run1 = 0; end
    cu = mode ? m_run1 : ones;
    cd = mode ? m_run0 : zeros;
    upc = (up_th != 0) && (cu >= int'(up_th));
    dnc = (dn_th != 0) && (cd >= int'(dn_th));
    old = m_state;
    if (m_state == 0) begin
      m_wcnt = (m_wcnt + 1) % 32;
      if (m_wcnt == L) m_state = upc ? 2 : 1;
    end else if (m_state == 1) begin
      if (upc) m_state = 2;
    end else if (dnc) begin
      m_state = 1;
    end
    m_eu = (m_state == 2) && (old != 2);
    m_ed = (old == 2) && (m_state == 1);
    if (m_eu && m_cnt < 255) m_cnt++;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.up = (m_state == 2); e.down = (m_state == 1);
    e.eu = m_eu; e.ed = m_ed; e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("up", 32'(up_o), 32'(e.up));
    chk("down", 32'(down_o), 32'(e.down));
`ifdef FDT_LABEL_EVT_EN
    chk("evt_up", 32'(eu_o), 32'(e.eu));
    chk("evt_down", 32'(ed_o), 32'(e.ed));
    chk("up_cnt", 32'(cnt_o), 32'(e.cnt));
`endif
  endtask

  task automatic send(input bit b);
    dec_result = b; dec_result_vld = 1'b1;
    mdl_sample(b); push_exp();
    @(posedge clk); #1;
    dec_result_vld = 1'b0;
    pop_cmp();
  endtask

  task automatic clr(input bit with_vld, input bit b);
    soft_clr = 1'b1; dec_result_vld = with_vld; dec_result = b;
    mdl_clr(); push_exp();
    @(posedge clk); #1;
    soft_clr = 1'b0; dec_result_vld = 1'b0;
    pop_cmp();
  endtask

  task automatic idle();
    m_eu = 1'b0; m_ed = 1'b0; push_exp();
    @(posedge clk); #1;
    pop_cmp();
  endtask

  task automatic cfg(input bit md, input int l, input int ut, input int dt, input bit ie);
    mode = md; len = 4'(l - 1); up_th = 5'(ut); dn_th = 5'(dt); init_en = ie;
  endtask

  initial begin
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up", 32'(up_o), 32'd0);
    chk("rst_down", 32'(down_o), 32'd1);
    rstn = 1'b1;
    idle();

    // window mode, L=8, thresholds 5/5
    phase = "win";
    cfg(0, 8, 5, 5, 0);
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("up_after5", 32'(up_o), 32'd1);
    for (int i = 0; i < 4; i++) send(1'b0);
    chk("up_hold", 32'(up_o), 32'd1);
    send(1'b0);
    chk("down_after5z", 32'(down_o), 32'd1);

    // run mode
    phase = "run";
    clr(0, 0);
    cfg(1, 8, 3, 2, 0);
    send(1); send(1); send(0); send(1); send(1);
    chk("not_yet_up", 32'(up_o), 32'd0);
    send(1);
    chk("up_final", 32'(up_o), 32'd1);
    send(0); send(1); send(0);
    chk("still_up", 32'(up_o), 32'd1);
    send(0);
    chk("down_final", 32'(down_o), 32'd1);

    // warmup with L=4
    phase = "warm";
    cfg(0, 4, 3, 2, 1);
    clr(0, 0);
    chk("clr_up", 32'(up_o), 32'd0);
    chk("clr_down", 32'(down_o), 32'd0);
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("warm_down", 32'(down_o), 32'd0);
    send(1'b1);
    chk("warm_exit_up", 32'(up_o), 32'd1);

    // soft_clr wins over a coincident sample
    phase = "drop";
    cfg(0, 4, 4, 4, 0);
    clr(1, 1);
    chk("clr_down", 32'(down_o), 32'd1);
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("no_up", 32'(up_o), 32'd0);
    send(1'b1);
    chk("up_4th", 32'(up_o), 32'd1);

    // up_th=0 disables DOWN->UP; run1 must saturate rather than wrap
    phase = "sat";
    cfg(1, 16, 0, 0, 0);
    clr(0, 0);
    for (int i = 0; i < 40; i++) send(1'b1);
    chk("never_up", 32'(up_o), 32'd0);
    up_th = 5'd31;
    send(1'b1);
    chk("sat31_up", 32'(up_o), 32'd1);

    // asynchronous reset mid-cycle, no clock edge needed
    phase = "arst";
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("async_up", 32'(up_o), 32'd0);
    chk("async_down", 32'(down_o), 32'd1);
    mdl_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // random traffic with config changes and occasional clears
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0)
        cfg(1'($urandom_range(0, 1)), $urandom_range(1, 16), $urandom_range(0, 17),
            $urandom_range(0, 17), 1'($urandom_range(0, 1)));
      case ($urandom_range(0, 19))
        0:       clr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1, 2:    idle();
        default: send(1'($urandom_range(0, 1)));
      endcase
    end

`ifdef FDT_LABEL_EVT_EN
    // 300 up/down toggles; event pulses checked each cycle, count saturates
    phase = "evt";
    cfg(1, 8, 1, 1, 0);
    clr(0, 0);
    for (int i = 0; i < 300; i++) begin
      send(1'b1);
      send(1'b0);
    end
    idle();
    chk("cnt_255", 32'(cnt_o), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
